// File: rtl/fnet_pcs_pkg.sv
// Shared 64b/66b PCS constants, block classification helpers and the RX buffer FSM state type.
package fnet_pcs_pkg;

  localparam logic [1:0] H_DATA  = 2'b01;
  localparam logic [1:0] H_CTRL  = 2'b10;
  localparam logic [7:0] T_IDLE  = 8'h00;
  localparam logic [7:0] T_START = 8'h78;
  localparam logic [7:0] T_ERROR = 8'h1E;
  localparam logic [6:0] E_CODE  = 7'h1E;

  // Control block types that carry a /T/ character (0..7 trailing data bytes).
  localparam logic [7:0] T_TERM_LIST [8] = '{8'h87, 8'h99, 8'hAA, 8'hB4,
                                             8'hCC, 8'hD2, 8'hE1, 8'hFF};

  // Block type lives in the low byte; the remaining 56 bits hold eight 7-bit /E/ codes.
  localparam logic [63:0] ERR_PAYLOAD = {{8{E_CODE}}, T_ERROR};

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_IN_FRAME = 2'd1,
    ST_DISCARD  = 2'd2,
    ST_ERR_PEND = 2'd3
  } rx_state_t;

  function automatic logic is_start(input logic [1:0] hdr, input logic [7:0] btype);
    return (hdr == H_CTRL) && (btype == T_START);
  endfunction

  function automatic logic is_term(input logic [1:0] hdr, input logic [7:0] btype);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (btype == T_TERM_LIST[i]) hit = 1'b1;
    end
    return (hdr == H_CTRL) && hit;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO: head entry is visible on rd_data while not empty.
module sync_fifo #(
  parameter int WIDTH = 66,
  parameter int DEPTH = 32,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  // Head is forced to zero when empty so stale storage never leaks out.
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rx_block_buffer.sv
// Frame-aware RX block buffer: FIFO with overflow discard and synthesized /E/ error block.
// Optional RX_BUF_STATS_EN adds drop_count / err_count saturating statistics outputs.
module rx_block_buffer
  import fnet_pcs_pkg::*;
#(
  parameter int DEPTH = 32,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] payload_in,
  input  logic [1:0]  header_in,
  input  logic        valid_in,
  output logic [63:0] payload_out,
  output logic [1:0]  header_out,
  output logic        valid_out,
  input  logic        ready_in,
  output logic        overflow,
  output logic [AW:0] fill_level,
`ifdef RX_BUF_STATS_EN
  output logic [31:0] drop_count,
  output logic [15:0] err_count,
`endif
  output rx_state_t   state_dbg
);

  // Output handshake: the head block transfers on any rising edge where valid_out && ready_in;
  // valid_out never depends on ready_in. The input side has no backpressure.

  rx_state_t   state;
  rx_state_t   state_nxt;
  logic        fifo_full;
  logic        fifo_empty;
  logic        wr_en;
  logic [65:0] wr_data;
  logic [65:0] rd_data;
  logic        blk_start;
  logic        blk_term;
  logic        drop;

  assign blk_start = is_start(header_in, payload_in[7:0]);
  assign blk_term  = is_term(header_in, payload_in[7:0]);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    wr_data   = {header_in, payload_in};
    drop      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (valid_in) begin
          if (fifo_full) begin
            drop = 1'b1;
          end else begin
            wr_en = 1'b1;
            if (blk_start) state_nxt = ST_IN_FRAME;
          end
        end
      end
      ST_IN_FRAME: begin
        if (valid_in) begin
          if (fifo_full) begin
            drop      = 1'b1;
            state_nxt = blk_term ? ST_ERR_PEND : ST_DISCARD;
          end else begin
            wr_en = 1'b1;
            if (blk_term) state_nxt = ST_IDLE;
          end
        end
      end
      ST_DISCARD: begin
        // A START here means the damaged frame never got its terminator; close it anyway.
        if (valid_in) begin
          drop = 1'b1;
          if (blk_term || blk_start) state_nxt = ST_ERR_PEND;
        end
      end
      ST_ERR_PEND: begin
        drop = valid_in;
        if (!fifo_full) begin
          wr_en     = 1'b1;
          wr_data   = {H_CTRL, ERR_PAYLOAD};
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  sync_fifo #(.WIDTH(66), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (ready_in),
    .rd_data (rd_data),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .count   (fill_level)
  );

  assign {header_out, payload_out} = rd_data;
  assign valid_out = !fifo_empty;
  assign overflow  = drop;
  assign state_dbg = state;

`ifdef RX_BUF_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_count <= '0;
      err_count  <= '0;
    end else begin
      if (drop && (drop_count != 32'hFFFF_FFFF)) drop_count <= drop_count + 1'b1;
      if (wr_en && (state == ST_ERR_PEND) && (err_count != 16'hFFFF)) err_count <= err_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_rx_block_buffer.sv
// Scoreboard bench for rx_block_buffer: directed scenarios plus randomized traffic vs a queue model.
module tb_rx_block_buffer;
  import fnet_pcs_pkg::*;

  localparam int DEPTH = 32;
  localparam int AW    = 5;
  localparam logic [65:0] ERR_BLK = {2'b10, {8{7'h1E}}, 8'h1E};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] payload_in = '0;
  logic [1:0]  header_in = '0;
  logic        valid_in = 1'b0;
  logic        ready_in = 1'b0;
  logic [63:0] payload_out;
  logic [1:0]  header_out;
  logic        valid_out;
  logic        overflow;
  logic [AW:0] fill_level;
  rx_state_t   state_dbg;
`ifdef RX_BUF_STATS_EN
  logic [31:0] drop_count;
  logic [15:0] err_count;
`endif

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  rx_block_buffer #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .payload_in  (payload_in),
    .header_in   (header_in),
    .valid_in    (valid_in),
    .payload_out (payload_out),
    .header_out  (header_out),
    .valid_out   (valid_out),
    .ready_in    (ready_in),
    .overflow    (overflow),
    .fill_level  (fill_level),
`ifdef RX_BUF_STATS_EN
    .drop_count  (drop_count),
    .err_count   (err_count),
`endif
    .state_dbg   (state_dbg)
  );

  // ---------------- scoreboard state ----------------
  logic [65:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [7:0]  term_types [8] = '{8'h87, 8'h99, 8'hAA, 8'hB4, 8'hCC, 8'hD2, 8'hE1, 8'hFF};

  // Reference model: frame bookkeeping as plain flags, FIFO contents are exp_q itself.
  bit      m_in_frame, m_discard, m_err_pend;
  longint  m_drops;
  int      m_errs;
  bit      chk_en = 1'b0;
  int      exp_fill;
  bit      exp_ovf;
  longint  exp_drops;
  int      exp_errs;
  int      ovf_seen = 0;

  task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit blk_is_term(input logic [65:0] b);
    bit hit = 0;
    for (int i = 0; i < 8; i++) if (b[7:0] == term_types[i]) hit = 1;
    return (b[65:64] == 2'b10) && hit;
  endfunction

  function automatic bit blk_is_start(input logic [65:0] b);
    return (b[65:64] == 2'b10) && (b[7:0] == 8'h78);
  endfunction

  // Apply one cycle of stimulus to the model; expected outputs for this cycle go to the monitor.
  task automatic model_step(input bit v, input logic [65:0] blk);
    bit full = (exp_q.size() == DEPTH);
    bit wr = 0;
    bit ovf = 0;
    logic [65:0] wdata = blk;
    exp_fill  = exp_q.size();
    exp_drops = m_drops;
    exp_errs  = m_errs;
    if (m_err_pend) begin
      ovf = v;
      if (!full) begin
        wr = 1; wdata = ERR_BLK; m_err_pend = 0; m_errs++;
      end
    end else if (m_discard) begin
      if (v) begin
        ovf = 1;
        if (blk_is_start(blk) || blk_is_term(blk)) begin
          m_discard = 0; m_err_pend = 1;
        end
      end
    end else if (v) begin
      if (full) begin
        ovf = 1;
        if (m_in_frame) begin
          m_in_frame = 0;
          if (blk_is_term(blk)) m_err_pend = 1;
          else m_discard = 1;
        end
      end else begin
        wr = 1;
        if (!m_in_frame && blk_is_start(blk)) m_in_frame = 1;
        else if (m_in_frame && blk_is_term(blk)) m_in_frame = 0;
      end
    end
    if (ovf) m_drops++;
    exp_ovf = ovf;
    chk_en  = 1;
    if (wr) exp_q.push_back(wdata);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input bit v, input logic [65:0] blk, input bit rdy);
    @(posedge clk); #1;
    rst        = 1'b0;
    valid_in   = v;
    header_in  = blk[65:64];
    payload_in = blk[63:0];
    ready_in   = rdy;
    model_step(v, blk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; valid_in = 1'b0; ready_in = 1'b0; chk_en = 0;
    exp_q.delete();
    m_in_frame = 0; m_discard = 0; m_err_pend = 0; m_drops = 0; m_errs = 0;
    ovf_seen = 0;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) drive(0, '0, rdy);
  endtask

  function automatic logic [65:0] mk_data(input logic [63:0] p);
    return {2'b01, p};
  endfunction

  function automatic logic [65:0] mk_ctrl(input logic [7:0] t);
    logic [63:0] p = {$urandom, $urandom};
    return {2'b10, p[63:8], t};
  endfunction

  function automatic logic [65:0] rand_blk();
    int k = $urandom_range(0, 9);
    if (k < 6) return mk_data({$urandom, $urandom});
    if (k == 6) return mk_ctrl(8'h78);
    if (k < 9) return mk_ctrl(term_types[$urandom_range(0, 7)]);
    return mk_ctrl(T_IDLE);
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("fill_level", 66'(fill_level), 66'(exp_fill));
      check("valid_out", 66'(valid_out), 66'(exp_fill != 0));
      check("overflow", 66'(overflow), 66'(exp_ovf));
`ifdef RX_BUF_STATS_EN
      check("drop_count", 66'(drop_count), 66'(exp_drops));
      check("err_count", 66'(err_count), 66'(exp_errs));
`endif
      if (overflow) ovf_seen++;
      if (valid_out && ready_in) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL block_out unexpected block actual=%h expected=none", {header_out, payload_out});
        end else begin
          check("block_out", {header_out, payload_out}, exp_q.pop_front());
        end
      end else if (!valid_out) begin
        check("empty_out", {header_out, payload_out}, 66'd0);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int rp;
    repeat (2) @(posedge clk);
    do_reset();

    // 1: three data blocks straight through
    idle(1, 1);
    for (int i = 1; i <= 3; i++) drive(1, mk_data(64'(i)), 1);
    idle(4, 1);

    // 2 + 4: fill to exactly DEPTH, then overflow, then read+write while full
    do_reset();
    drive(1, mk_ctrl(8'h78), 0);
    for (int i = 0; i < 30; i++) drive(1, mk_data({$urandom, $urandom}), 0);
    drive(1, mk_ctrl(8'hFF), 0);
    drive(1, mk_data(64'hDEAD), 0);
    drive(1, mk_data(64'hBEEF), 1);
    idle(40, 1);

    // 3: mid-frame overflow, ERRBLK after the 32nd block, next frame intact
    do_reset();
    drive(1, mk_ctrl(8'h78), 0);
    for (int i = 0; i < 40; i++) drive(1, mk_data(64'(100 + i)), 0);
    drive(1, mk_ctrl(8'h87), 0);
    idle(1, 0);
    check("ovf_pulses_s3", 66'(ovf_seen), 66'd10);
    idle(5, 1);
`ifdef RX_BUF_STATS_EN
    check("drop_count_s3", 66'(drop_count), 66'd10);
    check("err_count_s3", 66'(err_count), 66'd1);
`endif
    drive(1, mk_ctrl(8'h78), 1);
    for (int i = 0; i < 3; i++) drive(1, mk_data(64'(500 + i)), 1);
    drive(1, mk_ctrl(8'hB4), 1);
    idle(40, 1);

    // 5: reset mid-frame with 10 entries stored
    do_reset();
    drive(1, mk_ctrl(8'h78), 0);
    for (int i = 0; i < 9; i++) drive(1, mk_data(64'(i)), 0);
    idle(1, 0);
    do_reset();
    idle(3, 1);
    drive(1, mk_data(64'h55), 1);
    idle(3, 1);

    // Random traffic with shifting downstream throughput
    for (int blkn = 0; blkn < 15; blkn++) begin
      rp = $urandom_range(0, 100);
      for (int i = 0; i < 200; i++)
        drive($urandom_range(0, 99) < 80, rand_blk(), $urandom_range(0, 99) < rp);
    end

    idle(60, 1);
    check("drain_empty", 66'(exp_q.size()), 66'd0);
    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
